round_key_seq: RTL

ROUND_KEY_SEQ -- requirements
Module: round_key_seq

---
 rtl/round_key_seq_pkg.sv | 55 +++++
 rtl/rks_rotate.sv | 22 ++
 rtl/round_key_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/round_key_seq_pkg.sv
// rtl/round_key_seq_pkg.sv - DES key-schedule tables, widths, state enum and permutation helpers
package round_key_seq_pkg;

  localparam int KEY_W  = 64;
  localparam int HALF_W = 28;
  localparam int RK_W   = 48;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entries are 1-based DES bit numbers; bit 1 is the MSB of the source vector.
  localparam int PC1_TBL [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_TBL [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [2*HALF_W-1:0] r;
    logic [5:0]          idx;
    r = '0;
    for (int i = 0; i < 2*HALF_W; i++) begin
      idx = 6'(KEY_W - PC1_TBL[i]);
      r   = {r[2*HALF_W-2:0], key[idx]};
    end
    return r;
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [2*HALF_W-1:0] cd);
    logic [RK_W-1:0] r;
    logic [5:0]      idx;
    r = '0;
    for (int i = 0; i < RK_W; i++) begin
      idx = 6'(2*HALF_W - PC2_TBL[i]);
      r   = {r[RK_W-2:0], cd[idx]};
    end
    return r;
  endfunction

endpackage

// File: rtl/rks_rotate.sv
// rtl/rks_rotate.sv - 28-bit rotate by 0, 1 or 2 positions, left or right
module rks_rotate
  import round_key_seq_pkg::*;
(
  input  logic [HALF_W-1:0] i_data,
  input  logic [1:0]        i_amt,
  input  logic              i_left,
  output logic [HALF_W-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_amt)
      2'd1: o_data = i_left ? {i_data[HALF_W-2:0], i_data[HALF_W-1]}
                            : {i_data[0], i_data[HALF_W-1:1]};
      2'd2: o_data = i_left ? {i_data[HALF_W-3:0], i_data[HALF_W-1:HALF_W-2]}
                            : {i_data[1:0], i_data[HALF_W-1:2]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/round_key_seq.sv
// rtl/round_key_seq.sv - DES round-key sequencer, K1..K16 or K16..K1 over a valid/ready stream
// Optional key-byte odd-parity flag enabled by defining KEY_PARITY_CHK_EN.
module round_key_seq
  import round_key_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key,
  input  logic             decrypt,
  input  logic             abort,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  rk,
  output logic [3:0]       rk_round,
  output logic             rk_last,
  output logic             done,
  output logic             parity_err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HALF_W-1:0]   r_c;
  logic [HALF_W-1:0]   r_d;
  logic [3:0]          r_cnt;
  logic                r_dec;
  logic                r_done;

  logic                w_accept;
  logic                w_hs;
  logic [2*HALF_W-1:0] w_pc1;
  logic [HALF_W-1:0]   w_c_in;
  logic [HALF_W-1:0]   w_d_in;
  logic [HALF_W-1:0]   w_c_rot;
  logic [HALF_W-1:0]   w_d_rot;
  logic [1:0]          w_amt;
  logic                w_left;

  assign w_accept = key_valid & (r_state == ST_IDLE);
  assign w_hs     = (r_state == ST_RUN) & rk_ready & ~abort;
  assign w_pc1    = pc1(key);

  // One rotator pair serves both the load (PC-1 result, encrypt pre-rotated to C1/D1)
  // and each advance (encrypt rotates left by the next round's shift, decrypt right by the mirrored one).
  always_comb begin
    w_c_in = r_c;
    w_d_in = r_d;
    w_amt  = 2'd0;
    w_left = 1'b1;
    if (r_state == ST_IDLE) begin
      w_c_in = w_pc1[2*HALF_W-1:HALF_W];
      w_d_in = w_pc1[HALF_W-1:0];
      w_amt  = decrypt ? 2'd0 : 2'd1;
    end else if (r_dec) begin
      w_amt  = SHIFT_TBL[4'(4'd15 - r_cnt)];
      w_left = 1'b0;
    end else begin
      w_amt  = SHIFT_TBL[4'(r_cnt + 4'd1)];
    end
  end

  rks_rotate u_rot_c (
    .i_data (w_c_in),
    .i_amt  (w_amt),
    .i_left (w_left),
    .o_data (w_c_rot)
  );

  rks_rotate u_rot_d (
    .i_data (w_d_in),
    .i_amt  (w_amt),
    .i_left (w_left),
    .o_data (w_d_rot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (key_valid) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)                          w_state_nxt = ST_IDLE;
        else if (rk_ready && r_cnt == 4'd15) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_dec  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs & (r_cnt == 4'd15);
      if (w_accept) begin
        r_c   <= w_c_rot;
        r_d   <= w_d_rot;
        r_dec <= decrypt;
        r_cnt <= '0;
      end else if (w_hs) begin
        r_c   <= w_c_rot;
        r_d   <= w_d_rot;
        r_cnt <= (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
      end
    end
  end

  assign key_ready = (r_state == ST_IDLE);
  assign rk_valid  = (r_state == ST_RUN);
  assign rk        = pc2({r_c, r_d});
  assign rk_round  = r_cnt;
  assign rk_last   = rk_valid & (r_cnt == 4'd15);
  assign done      = r_done;

`ifdef KEY_PARITY_CHK_EN
  logic r_parity_err;
  logic w_par_fail;

  always_comb begin
    w_par_fail = 1'b0;
    for (int b = 0; b < KEY_W/8; b++) begin
      w_par_fail = w_par_fail | ~(^key[b*8 +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_parity_err <= 1'b0;
    else if (w_accept) r_parity_err <= w_par_fail;
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule
